// File: rtl/teller_dispatcher.sv
// Exit-side dispatcher for the bank queue: calls the lowest free teller, pulses phcTwo low,
// then waits for the queue counter to decrement. Optional per-teller service timeout: TELLER_TIMEOUT_EN.
module teller_dispatcher #(
   parameter int n           = 3,
   parameter int PULSE_LEN   = 4,
   parameter int GAP_LEN     = 3,
   parameter int ACK_TIMEOUT = 16,
   parameter int MAX_SERVICE = 255
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [n:0]   Pcount,
   input  logic         emptyFlag,
   input  logic [1:0]   Tcount,
   input  logic [2:0]   tellerDone,
   output logic         phcTwo,
   output logic [2:0]   tellerBusy,
   output logic [1:0]   callTeller,
   output logic         callValid,
   output logic         ackErr,
   output logic [2:0]   timeoutFlag,
   output logic [1:0]   fsm_state
);

   // Handshake: callValid is a one-cycle strobe; callTeller is valid with it and holds afterwards.
   // Ack from the queue is Pcount dropping strictly below the value latched at dispatch.

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PULSE    = 2'd1,
      WAIT_ACK = 2'd2
   } state_t;

   localparam int CW = 8;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [n:0]    latched, latched_n;
   logic          phc_n;
   logic [2:0]    busy_n;
   logic [1:0]    call_n;
   logic          valid_n;
   logic          ack_n;

   logic [2:0]    enabled;
   logic [2:0]    eligible;
   logic [1:0]    sel;
   logic [2:0]    sel_mask;
   logic          dispatch;
   logic          take;
   logic [2:0]    expire;
   logic [2:0]    release_mask;

   always_comb begin
      enabled = 3'b001;
      case (Tcount)
         2'd2:    enabled = 3'b011;
         2'd3:    enabled = 3'b111;
         default: enabled = 3'b001;
      endcase
   end

   // Eligibility deliberately uses the registered busy bits, so a teller freed on this
   // edge only becomes selectable on the next one.
   assign eligible = enabled & ~tellerBusy;

   always_comb begin
      sel      = 2'd0;
      sel_mask = 3'b000;
      if (eligible[0]) begin
         sel      = 2'd0;
         sel_mask = 3'b001;
      end else if (eligible[1]) begin
         sel      = 2'd1;
         sel_mask = 3'b010;
      end else if (eligible[2]) begin
         sel      = 2'd2;
         sel_mask = 3'b100;
      end
   end

   assign dispatch = (Pcount != '0) && !emptyFlag && (|eligible);

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      latched_n = latched;
      phc_n     = phcTwo;
      call_n    = callTeller;
      valid_n   = 1'b0;
      ack_n     = ackErr;
      take      = 1'b0;
      case (state)
         IDLE: begin
            phc_n = 1'b1;
            if (dispatch) begin
               state_n   = PULSE;
               phc_n     = 1'b0;
               call_n    = sel;
               valid_n   = 1'b1;
               latched_n = Pcount;
               cnt_n     = '0;
               take      = 1'b1;
            end
         end
         PULSE: begin
            if (cnt == CW'(PULSE_LEN - 1)) begin
               state_n = WAIT_ACK;
               phc_n   = 1'b1;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         WAIT_ACK: begin
            phc_n = 1'b1;
            if ((cnt >= CW'(GAP_LEN - 1)) && (Pcount < latched)) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
               // The called teller keeps its busy bit; only the queue handshake is abandoned.
               state_n = IDLE;
               ack_n   = 1'b1;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            phc_n   = 1'b1;
            cnt_n   = '0;
         end
      endcase
   end

   assign release_mask = (tellerDone & tellerBusy) | expire;

   always_comb begin
      busy_n = tellerBusy & ~release_mask;
      if (take) begin
         busy_n = busy_n | sel_mask;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         latched    <= '0;
         phcTwo     <= 1'b1;
         tellerBusy <= 3'b000;
         callTeller <= 2'd0;
         callValid  <= 1'b0;
         ackErr     <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         latched    <= latched_n;
         phcTwo     <= phc_n;
         tellerBusy <= busy_n;
         callTeller <= call_n;
         callValid  <= valid_n;
         ackErr     <= ack_n;
      end
   end

   assign fsm_state = state;

`ifdef TELLER_TIMEOUT_EN
   logic [CW-1:0] svc   [3];
   logic [CW-1:0] svc_n [3];
   logic [2:0]    tflag_n;

   // A tellerDone on the expiry edge wins: the teller is released normally with no flag.
   always_comb begin
      tflag_n = timeoutFlag;
      for (int i = 0; i < 3; i++) begin
         expire[i] = tellerBusy[i] && !tellerDone[i] && (svc[i] == CW'(MAX_SERVICE - 1));
         svc_n[i]  = svc[i];
         if (take && (sel == 2'(i))) begin
            svc_n[i] = '0;
         end else if (tellerBusy[i] && !expire[i]) begin
            svc_n[i] = svc[i] + 1'b1;
         end else if (expire[i]) begin
            svc_n[i] = '0;
         end
         if (expire[i]) begin
            tflag_n[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            svc[i] <= '0;
         end
         timeoutFlag <= 3'b000;
      end else begin
         for (int i = 0; i < 3; i++) begin
            svc[i] <= svc_n[i];
         end
         timeoutFlag <= tflag_n;
      end
   end
`else
   logic [CW-1:0] unused_max_service;

   assign unused_max_service = CW'(MAX_SERVICE);
   assign expire             = 3'b000;
   assign timeoutFlag        = 3'b000;
`endif

endmodule
